// File: rtl/fetch_pkg.sv
// Shared types and address-slicing helpers for the instruction fetch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH_W0 = 2'd1,
      FETCH_W1 = 2'd2
   } fetch_state_e;

   // Byte distance between the two words of an instruction pair.
   localparam int WORD_OFF = 4;
   // Lowest address bit that selects a word (bits below it are the byte offset).
   localparam int WORD_LSB = 2;

   // Lowest tag bit: the index occupies [tag_lsb-1:WORD_LSB].
   function automatic int tag_lsb(input int depth_log2);
      return depth_log2 + WORD_LSB;
   endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Request/acknowledge bus between the fetch buffer and instruction memory.
// Latency: memory decides; mem_ack pulses for one cycle with mem_rdata.
// Backpressure: mem_req and mem_adr hold steady until mem_ack.
interface inst_fetch_buffer_if #(
   parameter int ADR_W = 32
);
   logic             mem_req;
   logic [ADR_W-1:0] mem_adr;
   logic             mem_ack;
   logic [31:0]      mem_rdata;

   modport master (output mem_req, output mem_adr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_adr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_word_store.sv
// Direct-mapped word store: data/tag/valid per entry, two lookup ports, one write port.
// Latency: reads and hit flags are combinational; writes land on the next edge.
// Backpressure: none; a clear in the same cycle as a write leaves the entry invalid.
module fetch_word_store #(
   parameter int DEPTH_LOG2 = 4,
   parameter int TAG_W      = 26
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [DEPTH_LOG2-1:0] rd_idx0,
   input  logic [TAG_W-1:0]      rd_tag0,
   output logic                  rd_hit0,
   output logic [31:0]           rd_dat0,
   input  logic [DEPTH_LOG2-1:0] rd_idx1,
   input  logic [TAG_W-1:0]      rd_tag1,
   output logic                  rd_hit1,
   output logic [31:0]           rd_dat1,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [31:0]           wr_dat
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]      dat_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [DEPTH-1:0] vld;

   // Valid bits: cleared by reset or flush, set by a fill.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         vld <= '0;
      end else if (wr_en) begin
         vld[wr_idx] <= 1'b1;
      end
   end

   // Payload arrays need no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         dat_mem[wr_idx] <= wr_dat;
         tag_mem[wr_idx] <= wr_tag;
      end
   end

   assign rd_dat0 = dat_mem[rd_idx0];
   assign rd_dat1 = dat_mem[rd_idx1];
   assign rd_hit0 = vld[rd_idx0] && (tag_mem[rd_idx0] == rd_tag0);
   assign rd_hit1 = vld[rd_idx1] && (tag_mem[rd_idx1] == rd_tag1);

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction pair buffer in front of a 32-bit variable-latency memory; fetches missing words.
// Latency: hit delivers the pair same cycle; miss of both words = 1 + 2 memory round trips.
// Backpressure: inst_valid stays low until both words are resident; mem request held until ack.
module inst_fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int ADR_W      = 32,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADR_W-1:0]     inst_adr,
   input  logic                 invalidate,
   output logic [63:0]          inst,
   output logic                 inst_valid,
   inst_fetch_buffer_if.master  mem,
   output logic [CNT_W-1:0]     miss_count
);
   localparam int TAG_LSB = tag_lsb(DEPTH_LOG2);
   localparam int TAG_W   = ADR_W - TAG_LSB;

   fetch_state_e     state;
   logic             req_q;
   logic [ADR_W-1:0] adr_q;
   logic             drop;

   logic [ADR_W-1:0] w0;
   logic [ADR_W-1:0] w1;
   logic             hit0;
   logic             hit1;
   logic [31:0]      dat0;
   logic [31:0]      dat1;
   logic             wr_en;
   logic             unused_bits;

   // Second word wraps naturally modulo 2^ADR_W.
   assign w0 = {inst_adr[ADR_W-1:WORD_LSB], 2'b00};
   assign w1 = w0 + ADR_W'(WORD_OFF);

   // A returning word is stored unless a flush arrived while it was in flight or with it.
   assign wr_en = mem.mem_ack && (state != IDLE) && !drop && !invalidate;

   fetch_word_store #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .TAG_W      (TAG_W)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .clear   (invalidate),
      .rd_idx0 (w0[TAG_LSB-1:WORD_LSB]),
      .rd_tag0 (w0[ADR_W-1:TAG_LSB]),
      .rd_hit0 (hit0),
      .rd_dat0 (dat0),
      .rd_idx1 (w1[TAG_LSB-1:WORD_LSB]),
      .rd_tag1 (w1[ADR_W-1:TAG_LSB]),
      .rd_hit1 (hit1),
      .rd_dat1 (dat1),
      .wr_en   (wr_en),
      .wr_idx  (adr_q[TAG_LSB-1:WORD_LSB]),
      .wr_tag  (adr_q[ADR_W-1:TAG_LSB]),
      .wr_dat  (mem.mem_rdata)
   );

   assign inst          = {dat1, dat0};
   assign inst_valid    = hit0 && hit1;
   assign mem.mem_req   = req_q;
   assign mem.mem_adr   = adr_q;
   // Byte-offset bits never take part in lookup or fill.
   assign unused_bits   = ^{inst_adr[1:0], adr_q[1:0]};

   // Miss FSM: launches fills, tracks flushes of in-flight words, counts miss episodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         adr_q      <= '0;
         drop       <= 1'b0;
         miss_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!hit0 || !hit1) begin
                  state <= hit0 ? FETCH_W1 : FETCH_W0;
                  req_q <= 1'b1;
                  adr_q <= hit0 ? w1 : w0;
                  if (miss_count != '1) begin
                     miss_count <= miss_count + 1'b1;
                  end
               end
            end
            FETCH_W0: begin
               if (mem.mem_ack) begin
                  drop <= 1'b0;
                  // hit1 reflects the store before this fill, so a w1 that
                  // equals the word being written still counts as a miss.
                  if (!drop && !invalidate && !hit1) begin
                     state <= FETCH_W1;
                     adr_q <= w1;
                  end else begin
                     state <= IDLE;
                     req_q <= 1'b0;
                  end
               end else if (invalidate) begin
                  drop <= 1'b1;
               end
            end
            FETCH_W1: begin
               if (mem.mem_ack) begin
                  drop  <= 1'b0;
                  state <= IDLE;
                  req_q <= 1'b0;
               end else if (invalidate) begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with a variable-latency memory model.
// Latency: n/a.
// Backpressure: memory acks after a programmable number of request cycles.
module tb_inst_fetch_buffer;
   localparam int ADR_W = 32;
   localparam int DL2   = 4;
   localparam int CW    = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [31:0]     inst_adr = '0;
   logic            invalidate = 1'b0;
   logic [63:0]     inst;
   logic            inst_valid;
   logic [CW-1:0]   miss_count;

   inst_fetch_buffer_if #(.ADR_W(ADR_W)) mif ();

   inst_fetch_buffer #(
      .DEPTH_LOG2 (DL2),
      .ADR_W      (ADR_W),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_adr   (inst_adr),
      .invalidate (invalidate),
      .inst       (inst),
      .inst_valid (inst_valid),
      .mem        (mif),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mw(input logic [31:0] a);
      if (a == 32'h0) return 32'h1111_1111;
      if (a == 32'h4) return 32'h2222_2222;
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory model: acks after `lat` request cycles, logs every acked address,
   // and counts cycles where an unacked request changed or vanished.
   int          lat = 1;
   int          cnt = 0;
   int          bp_viol = 0;
   logic        prev_req = 1'b0;
   logic [31:0] prev_adr = '0;
   logic [31:0] log_q [$];

   initial begin
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = '0;
   end

   always @(negedge clk) begin
      if (prev_req && !mif.mem_ack && !rst &&
          (!mif.mem_req || mif.mem_adr != prev_adr)) bp_viol++;
      prev_req = mif.mem_req;
      prev_adr = mif.mem_adr;
      if (rst || !mif.mem_req) begin
         mif.mem_ack   = 1'b0;
         mif.mem_rdata = '0;
         cnt = 0;
      end else begin
         cnt = mif.mem_ack ? 1 : cnt + 1;
         if (cnt >= lat) begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mw(mif.mem_adr);
            log_q.push_back(mif.mem_adr);
         end else begin
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = '0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!inst_valid && cyc < 60) begin
         step();
         cyc++;
      end
   endtask

   typedef struct {
      logic [31:0]   adr;
      int            lat;
      int            n;
      logic [31:0]   r0;
      logic [31:0]   r1;
      logic [63:0]   inst;
      logic [CW-1:0] miss;
      int            cyc;
   } vec_t;

   vec_t vt [18];

   initial begin
      int          cyc;
      logic [31:0] got;

      vt[0]  = '{32'h4,        1, 1, 32'h8,        32'h0,  {mw(32'h8),  mw(32'h4)},  4'd2,  2};
      vt[1]  = '{32'h0,        1, 0, 32'h0,        32'h0,  {mw(32'h4),  mw(32'h0)},  4'd2,  0};
      vt[2]  = '{32'h3C,       2, 2, 32'h3C,       32'h40, {mw(32'h40), mw(32'h3C)}, 4'd3,  5};
      vt[3]  = '{32'h0,        1, 1, 32'h0,        32'h0,  {mw(32'h4),  mw(32'h0)},  4'd4,  2};
      vt[4]  = '{32'h43,       3, 2, 32'h40,       32'h44, {mw(32'h44), mw(32'h40)}, 4'd5,  7};
      vt[5]  = '{32'h40,       1, 0, 32'h0,        32'h0,  {mw(32'h44), mw(32'h40)}, 4'd5,  0};
      vt[6]  = '{32'hFFFFFFFC, 1, 2, 32'hFFFFFFFC, 32'h0,  {mw(32'h0),  mw(32'hFFFFFFFC)}, 4'd6, 3};
      vt[7]  = '{32'h0,        1, 1, 32'h4,        32'h0,  {mw(32'h4),  mw(32'h0)},  4'd7,  2};
      vt[8]  = '{32'h80,       6, 2, 32'h80,       32'h84, {mw(32'h84), mw(32'h80)}, 4'd8,  13};
      for (int i = 9; i < 18; i++) begin
         if (i % 2 == 1)
            vt[i] = '{32'h0,  1, 2, 32'h0,  32'h4,  {mw(32'h4),  mw(32'h0)},  4'd0, 3};
         else
            vt[i] = '{32'h40, 1, 2, 32'h40, 32'h44, {mw(32'h44), mw(32'h40)}, 4'd0, 3};
         vt[i].miss = (i <= 15) ? CW'(i) : 4'hF;
      end

      // Reset state
      rst = 1'b1; inst_adr = 32'h0; lat = 1;
      step(); step();
      chk("rst_inst_valid", 64'(inst_valid), 64'(0));
      chk("rst_mem_req",    64'(mif.mem_req), 64'(0));
      chk("rst_mem_adr",    64'(mif.mem_adr), 64'(0));
      chk("rst_miss_count", 64'(miss_count), 64'(0));

      // Cold start: exact latency for a double miss
      rst = 1'b0; #1;
      step();
      chk("cold_req_w0", 64'({mif.mem_req, mif.mem_adr}), 64'({1'b1, 32'h0}));
      step();
      chk("cold_req_w1", 64'({mif.mem_req, mif.mem_adr}), 64'({1'b1, 32'h4}));
      chk("cold_valid_early", 64'(inst_valid), 64'(0));
      step();
      chk("cold_valid", 64'(inst_valid), 64'(1));
      chk("cold_inst",  inst, 64'h2222_2222_1111_1111);
      chk("cold_miss",  64'(miss_count), 64'(1));
      chk("cold_nreq",  64'(log_q.size()), 64'(2));

      // Table-driven vectors
      for (int i = 0; i < 18; i++) begin
         log_q.delete();
         lat = vt[i].lat;
         inst_adr = vt[i].adr;
         #1;
         wait_valid(cyc);
         chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vt[i].cyc));
         chk($sformatf("v%0d_inst", i), inst, vt[i].inst);
         chk($sformatf("v%0d_miss", i), 64'(miss_count), 64'(vt[i].miss));
         chk($sformatf("v%0d_nreq", i), 64'(log_q.size()), 64'(vt[i].n));
         for (int k = 0; k < vt[i].n; k++) begin
            got = (k < log_q.size()) ? log_q[k] : 32'hDEAD_BEEF;
            chk($sformatf("v%0d_req%0d", i, k), 64'(got), 64'((k == 0) ? vt[i].r0 : vt[i].r1));
         end
      end

      // Invalidate while FETCH_W0 outstanding
      log_q.delete();
      lat = 4;
      inst_adr = 32'h108;
      #1;
      step();
      chk("inv_req", 64'({mif.mem_req, mif.mem_adr}), 64'({1'b1, 32'h108}));
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      step(); step(); step();
      chk("inv_back_idle", 64'(mif.mem_req), 64'(0));
      step();
      chk("inv_refetch", 64'({mif.mem_req, mif.mem_adr}), 64'({1'b1, 32'h108}));
      wait_valid(cyc);
      chk("inv_inst", inst, {mw(32'h10C), mw(32'h108)});
      chk("inv_nreq", 64'(log_q.size()), 64'(3));
      log_q.delete();
      lat = 1;
      inst_adr = 32'h0;
      #1;
      chk("inv_pair_cleared", 64'(inst_valid), 64'(0));
      wait_valid(cyc);
      chk("inv_pair_refill", 64'(log_q.size()), 64'(2));

      // Invalidate coincident with ack: word discarded, full refetch
      log_q.delete();
      inst_adr = 32'h200;
      #1;
      step();
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      wait_valid(cyc);
      chk("coinc_nreq", 64'(log_q.size()), 64'(3));
      chk("coinc_inst", inst, {mw(32'h204), mw(32'h200)});

      // Reset during FETCH_W1
      lat = 3;
      inst_adr = 32'h300;
      #1;
      cyc = 0;
      while (mif.mem_adr != 32'h304 && cyc < 30) begin
         step();
         cyc++;
      end
      chk("rstw1_reached", 64'({mif.mem_req, mif.mem_adr}), 64'({1'b1, 32'h304}));
      rst = 1'b1;
      step();
      chk("rstw1_mem_req",    64'(mif.mem_req), 64'(0));
      chk("rstw1_inst_valid", 64'(inst_valid), 64'(0));
      chk("rstw1_miss_count", 64'(miss_count), 64'(0));
      rst = 1'b0;

      chk("bp_stable", 64'(bp_viol), 64'(0));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
